// File: rtl/addr_xlate_slice.sv
// -----------------------------------------------------------------------------
// addr_xlate_slice
//
// Translates a bus-bridge address into a system-bus address and flags offsets
// that fall outside the selected slave's memory. The translated beat is held in
// a two-entry elastic buffer (output register plus one skid register). Because
// of the skid register, bb_ready comes from a flop and has no combinational path
// from bus_ready.
//
// Address mapping:
//   sel      = bb_addr[BB_ADDR_WIDTH-1 -: SLAVE_SEL_WIDTH]
//   off      = bb_addr[BB_ADDR_WIDTH-SLAVE_SEL_WIDTH-1:0]
//   bus_addr = {0..., sel, off zero-extended to BUS_MEM_ADDR_WIDTH}
//   bus_err  = (off >= SLAVE_MEM_DEPTH); the beat is still forwarded.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   bb_addr    in   upstream address
//   bb_valid   in   upstream beat valid
//   bb_ready   out  upstream ready (registered)
//   bus_addr   out  translated address
//   bus_err    out  offset out of range for the selected slave
//   bus_valid  out  downstream beat valid
//   bus_ready  in   downstream ready
//   stats_clr  in   clear both statistics counters      (ADDR_XLATE_STATS_EN)
//   xlate_cnt  out  saturating count of downstream beats (ADDR_XLATE_STATS_EN)
//   err_cnt    out  saturating count of beats with error (ADDR_XLATE_STATS_EN)
//
// Optional feature macro: ADDR_XLATE_STATS_EN adds the statistics counters.
// -----------------------------------------------------------------------------
module addr_xlate_slice #(
  parameter int BB_ADDR_WIDTH      = 12,
  parameter int BUS_ADDR_WIDTH     = 16,
  parameter int BUS_MEM_ADDR_WIDTH = 12,
  parameter int SLAVE_SEL_WIDTH    = 1,
  parameter int SLAVE_MEM_DEPTH    = 2**(BB_ADDR_WIDTH-SLAVE_SEL_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BB_ADDR_WIDTH-1:0]  bb_addr,
  input  logic                      bb_valid,
  output logic                      bb_ready,
  output logic [BUS_ADDR_WIDTH-1:0] bus_addr,
  output logic                      bus_err,
  output logic                      bus_valid,
  input  logic                      bus_ready
`ifdef ADDR_XLATE_STATS_EN
  ,
  input  logic                      stats_clr,
  output logic [15:0]               xlate_cnt,
  output logic [15:0]               err_cnt
`endif
);

  localparam int OFF_W = BB_ADDR_WIDTH - SLAVE_SEL_WIDTH;
  // One extra bit so a depth equal to 2**OFF_W still compares correctly.
  localparam logic [32:0] DEPTH_W = 33'(SLAVE_MEM_DEPTH);

  // Configurations that would drop offset or select bits are rejected.
  if ((OFF_W > BUS_MEM_ADDR_WIDTH) ||
      ((BUS_MEM_ADDR_WIDTH + SLAVE_SEL_WIDTH) > BUS_ADDR_WIDTH)) begin : g_bad_cfg
    $error("addr_xlate_slice: address fields do not fit the bus address");
  end

  typedef struct packed {
    logic                      err;
    logic [BUS_ADDR_WIDTH-1:0] addr;
  } beat_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  // Address translation and range check, applied before anything is stored.
  function automatic beat_t xlate(input logic [BB_ADDR_WIDTH-1:0] a);
    beat_t                      b;
    logic [SLAVE_SEL_WIDTH-1:0] sel;
    logic [OFF_W-1:0]           off;
    sel                                      = a[BB_ADDR_WIDTH-1 -: SLAVE_SEL_WIDTH];
    off                                      = a[OFF_W-1:0];
    b.addr                                   = '0;
    b.addr[OFF_W-1:0]                        = off;
    b.addr[BUS_MEM_ADDR_WIDTH +: SLAVE_SEL_WIDTH] = sel;
    b.err                                    = (33'(off) >= DEPTH_W);
    return b;
  endfunction

  state_t state_q, state_d;
  beat_t  out_q, out_d;
  beat_t  skid_q, skid_d;
  logic   bus_valid_q, bus_valid_d;
  logic   bb_ready_q, bb_ready_d;
  beat_t  in_beat;
  logic   up_xfer;
  logic   dn_xfer;

  assign in_beat = xlate(bb_addr);
  assign up_xfer = bb_valid && bb_ready_q;
  assign dn_xfer = bus_valid_q && bus_ready;

  // Next-state and datapath steering for the two-entry buffer.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (up_xfer) begin
          out_d   = in_beat;
          state_d = S_ONE;
        end else begin
          state_d = S_EMPTY;
        end
      end
      S_ONE: begin
        if (up_xfer && dn_xfer) begin
          // Output drains while a new beat arrives: new beat goes straight out.
          out_d   = in_beat;
          state_d = S_ONE;
        end else if (up_xfer) begin
          skid_d  = in_beat;
          state_d = S_FULL;
        end else if (dn_xfer) begin
          state_d = S_EMPTY;
        end else begin
          state_d = S_ONE;
        end
      end
      S_FULL: begin
        // bb_ready is low here, so only the downstream side can move.
        if (dn_xfer) begin
          out_d   = skid_q;
          state_d = S_ONE;
        end else begin
          state_d = S_FULL;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
    bus_valid_d = (state_d != S_EMPTY);
    bb_ready_d  = (state_d != S_FULL);
  end

  // Buffer state, held beats and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      bus_valid_q <= 1'b0;
      bb_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      bus_valid_q <= bus_valid_d;
      bb_ready_q  <= bb_ready_d;
    end
  end

  assign bus_addr  = out_q.addr;
  assign bus_err   = out_q.err;
  assign bus_valid = bus_valid_q;
  assign bb_ready  = bb_ready_q;

`ifdef ADDR_XLATE_STATS_EN
  logic [15:0] xlate_cnt_q, xlate_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating statistics; a clear beats a same-cycle increment.
  always_comb begin
    xlate_cnt_d = xlate_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (stats_clr) begin
      xlate_cnt_d = 16'h0000;
      err_cnt_d   = 16'h0000;
    end else if (dn_xfer) begin
      if (xlate_cnt_q != 16'hFFFF) begin
        xlate_cnt_d = xlate_cnt_q + 16'h0001;
      end else begin
        xlate_cnt_d = xlate_cnt_q;
      end
      if (out_q.err && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_d = err_cnt_q + 16'h0001;
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else begin
      xlate_cnt_d = xlate_cnt_q;
      err_cnt_d   = err_cnt_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      xlate_cnt_q <= 16'h0000;
      err_cnt_q   <= 16'h0000;
    end else begin
      xlate_cnt_q <= xlate_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign xlate_cnt = xlate_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_addr_xlate_slice.sv
// -----------------------------------------------------------------------------
// Testbench for addr_xlate_slice.
// Two instances share one stimulus stream:
//   dut  : SLAVE_SEL_WIDTH=1, SLAVE_MEM_DEPTH=1024 (offsets 1024..2047 error)
//   dut2 : SLAVE_SEL_WIDTH=2, defaults otherwise
// Inputs change on the falling edge; a scoreboard queue per instance holds the
// expected beats and a monitor compares outputs in the middle of the low phase.
// -----------------------------------------------------------------------------
module tb_addr_xlate_slice;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] bb_addr = 12'h000;
  logic        bb_valid = 1'b0;
  logic        bus_ready = 1'b0;
  logic        stats_clr = 1'b0;
  logic        bb_ready, bus_err, bus_valid;
  logic [15:0] bus_addr;
  logic        bb_ready2, bus_err2, bus_valid2;
  logic [15:0] bus_addr2;
`ifdef ADDR_XLATE_STATS_EN
  logic [15:0] xlate_cnt, err_cnt, xlate_cnt2, err_cnt2;
`endif

  int total = 0;
  int bad   = 0;
  bit rand_en = 1'b0;
  logic [16:0] q1[$];
  logic [16:0] q2[$];
  int mx = 0;
  int me = 0;

  always #5 clk = ~clk;

  addr_xlate_slice #(.SLAVE_MEM_DEPTH(1024)) dut (
    .clk(clk), .rst(rst), .bb_addr(bb_addr), .bb_valid(bb_valid), .bb_ready(bb_ready),
    .bus_addr(bus_addr), .bus_err(bus_err), .bus_valid(bus_valid), .bus_ready(bus_ready)
`ifdef ADDR_XLATE_STATS_EN
    , .stats_clr(stats_clr), .xlate_cnt(xlate_cnt), .err_cnt(err_cnt)
`endif
  );

  addr_xlate_slice #(.SLAVE_SEL_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .bb_addr(bb_addr), .bb_valid(bb_valid), .bb_ready(bb_ready2),
    .bus_addr(bus_addr2), .bus_err(bus_err2), .bus_valid(bus_valid2), .bus_ready(bus_ready)
`ifdef ADDR_XLATE_STATS_EN
    , .stats_clr(stats_clr), .xlate_cnt(xlate_cnt2), .err_cnt(err_cnt2)
`endif
  );

  // Reference: 1 select bit (2048-word windows), slaves hold 1024 words.
  function automatic logic [16:0] model1(input int a);
    int   sel = a / 2048;
    int   off = a % 2048;
    logic e   = (off >= 1024);
    logic [15:0] ad = 16'(sel * 4096 + off);
    return {e, ad};
  endfunction

  // Reference: 2 select bits (1024-word windows), whole window valid.
  function automatic logic [16:0] model2(input int a);
    int   sel = a / 1024;
    int   off = a % 1024;
    logic [15:0] ad = 16'(sel * 4096 + off);
    return {1'b0, ad};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Random downstream back-pressure when enabled.
  always @(negedge clk) begin
    if (rand_en) bus_ready = 1'($urandom_range(0, 1));
  end

  // Stimulus side of the scoreboard: record every accepted beat.
  always @(negedge clk) begin
    #3;
    if (!rst && bb_valid && bb_ready) begin
      q1.push_back(model1(int'(bb_addr)));
      q2.push_back(model2(int'(bb_addr)));
    end
  end

  // Monitor: compare outputs against the scoreboard and update counter model.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      logic dn;
      logic e;
      dn = (q1.size() != 0) && bus_ready;
      e  = (q1.size() != 0) ? q1[0][16] : 1'b0;
      chk("valid1", 32'(bus_valid), 32'(q1.size() != 0));
      chk("ready1", 32'(bb_ready), 32'(q1.size() < 2));
      chk("valid2", 32'(bus_valid2), 32'(q2.size() != 0));
      chk("ready2", 32'(bb_ready2), 32'(q2.size() < 2));
      if (bus_valid && q1.size() != 0) begin
        chk("beat1", {15'd0, bus_err, bus_addr}, {15'd0, q1[0]});
        if (bus_ready) void'(q1.pop_front());
      end
      if (bus_valid2 && q2.size() != 0) begin
        chk("beat2", {15'd0, bus_err2, bus_addr2}, {15'd0, q2[0]});
        if (bus_ready) void'(q2.pop_front());
      end
`ifdef ADDR_XLATE_STATS_EN
      chk("xlate_cnt", 32'(xlate_cnt), 32'(mx));
      chk("err_cnt", 32'(err_cnt), 32'(me));
      chk("xlate_cnt2", 32'(xlate_cnt2), 32'(mx));
      chk("err_cnt2", 32'(err_cnt2), 32'd0);
`endif
      if (stats_clr) begin
        mx = 0;
        me = 0;
      end else if (dn) begin
        if (mx < 65535) mx++;
        if (e && me < 65535) me++;
      end
    end
  end

  // Called on a falling edge; returns on a falling edge.
  task automatic do_reset();
    rst = 1'b1;
    bb_valid = 1'b0;
    @(posedge clk);
    #1;
    q1.delete();
    q2.delete();
    mx = 0;
    me = 0;
    chk("rst_valid", 32'(bus_valid), 32'd0);
    chk("rst_ready", 32'(bb_ready), 32'd1);
    chk("rst_addr", 32'(bus_addr), 32'd0);
    chk("rst_err", 32'(bus_err), 32'd0);
    chk("rst_valid2", 32'(bus_valid2), 32'd0);
`ifdef ADDR_XLATE_STATS_EN
    chk("rst_xlate_cnt", 32'(xlate_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer one beat and hold it until accepted (bounded).
  task automatic send(input logic [11:0] a);
    bit ok = 1'b0;
    bb_addr  = a;
    bb_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      #1;
      if (bb_ready === 1'b1) ok = 1'b1;
      @(negedge clk);
    end
    chk("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic idle(input int n);
    bb_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Basic translation, error flag, two select bits.
    bus_ready = 1'b1;
    send(12'h8A5);
    idle(3);
    send(12'h400);
    idle(3);
`ifdef ADDR_XLATE_STATS_EN
    #1;
    chk("err_cnt_after_400", 32'(err_cnt), 32'd1);
    chk("xlate_cnt_after_400", 32'(xlate_cnt), 32'd2);
    @(negedge clk);
`endif
    send(12'hC10);
    idle(3);

    // Back-pressure: third beat is refused until the buffer drains.
    do_reset();
    bus_ready = 1'b0;
    send(12'h001);
    send(12'h802);
    bb_addr  = 12'h003;
    bb_valid = 1'b1;
    repeat (3) begin
      #1;
      chk("full_ready", 32'(bb_ready), 32'd0);
      @(negedge clk);
    end
    bus_ready = 1'b1;
    send(12'h003);
    idle(4);

    // Random traffic with random back-pressure.
    rand_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else send(12'($urandom_range(0, 4095)));
    end
    rand_en = 1'b0;
    bus_ready = 1'b1;
    idle(4);

    // Reset while full: nothing stale may come out afterwards.
    do_reset();
    bus_ready = 1'b0;
    send(12'h111);
    send(12'h922);
    do_reset();
    bus_ready = 1'b1;
    idle(5);

`ifdef ADDR_XLATE_STATS_EN
    // Counter saturation, then a clear coinciding with a transfer.
    do_reset();
    bus_ready = 1'b1;
    repeat (65535) send(12'h001);
    send(12'h002);
    send(12'h004);
    #1;
    chk("xlate_sat", 32'(xlate_cnt), 32'h0000FFFF);
    @(negedge clk);
    stats_clr = 1'b1;
    bb_addr = 12'h003;
    #1;
    chk("clr_cycle_xfer", 32'(bus_valid), 32'd1);
    @(negedge clk);
    stats_clr = 1'b0;
    bb_valid = 1'b0;
    #1;
    chk("xlate_clr", 32'(xlate_cnt), 32'd0);
    @(negedge clk);
    idle(3);
`endif

    chk("drained1", 32'(q1.size()), 32'd0);
    chk("drained2", 32'(q2.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
